// File: rtl/rv_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package rv_pkg;
    localparam int XLEN_DEFAULT = 64;
    localparam int INST_W       = 32;
    localparam int PC_STEP      = 4;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [INST_W-1:0]       inst;
    } fetch_entry_t;
endpackage

// File: rtl/rv_fetch_unit_fifo.sv
// Flushable synchronous FIFO of {pc, inst} entries; depth need not be a power of two.
module fetch_fifo
    import rv_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_entry,
    input  logic          pop,
    output logic          head_valid,
    output fetch_entry_t  head_entry,
    output logic [CW-1:0] count
);
    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign full       = (count == CW'(DEPTH));
    assign head_valid = (count != '0);
    assign head_entry = mem[rd_ptr];
    assign do_pop     = pop && head_valid;
    // A pop frees the head slot this cycle, so a push into a full FIFO is still safe.
    assign do_push    = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush && do_push) mem[wr_ptr] <= push_entry;
    end
endmodule

// File: rtl/rv_fetch_unit.sv
// Decoupled instruction-fetch front end: PC ownership, 1-cycle imem requests, buffered output.
// Optional fetch_stall_cycles counter enabled by defining RV_FETCH_PERF_EN.
module rv_fetch_unit
    import rv_pkg::*;
#(
    parameter  int              XLEN       = XLEN_DEFAULT,
    parameter  int              FIFO_DEPTH = 4,
    parameter  logic [XLEN-1:0] RESET_PC   = '0,
    localparam int              CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [XLEN-1:0]   out_pc,
    output logic [CW-1:0]     fifo_count
`ifdef RV_FETCH_PERF_EN
   ,output logic [31:0]       fetch_stall_cycles
`endif
);
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic            flush_pending;
    logic            reset_q;
    logic [CW:0]     occupancy;
    logic            accept;
    logic            fifo_push;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;
    logic            unused_pc_lsbs;

    assign unused_pc_lsbs = ^redirect_pc[1:0];

    // In-flight request reserves a slot so its response always has room.
    assign occupancy      = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
    assign imem_req_valid = !reset && !redirect_valid && (occupancy < (CW + 1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign fifo_push      = imem_rsp_valid && inflight && !flush_pending && !redirect_valid;

    always_comb begin
        push_entry      = '0;
        push_entry.pc   = XLEN_DEFAULT'(inflight_pc);
        push_entry.inst = imem_rsp_data;
    end

    always_ff @(posedge clk) begin
        reset_q <= reset;
        if (reset) begin
            fetch_pc      <= RESET_PC;
            inflight_pc   <= '0;
            inflight      <= 1'b0;
            flush_pending <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc      <= {redirect_pc[XLEN-1:2], 2'b00};
            inflight      <= 1'b0;
            flush_pending <= 1'b1;
        end else begin
            flush_pending <= 1'b0;
            if (accept) begin
                fetch_pc    <= fetch_pc + XLEN'(PC_STEP);
                inflight_pc <= fetch_pc;
                inflight    <= 1'b1;
            end else begin
                inflight    <= 1'b0;
            end
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (out_ready),
        .head_valid (out_valid),
        .head_entry (head_entry),
        .count      (fifo_count)
    );

    assign out_inst = head_entry.inst;
    assign out_pc   = head_entry.pc[XLEN-1:0];

`ifdef RV_FETCH_PERF_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_ready && !out_valid && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign fetch_stall_cycles = stall_cnt;
`endif

    // Responses around reset are dropped silently; any other orphan response is a memory bug.
    assert property (@(posedge clk) disable iff (reset || reset_q) imem_rsp_valid |-> inflight);
endmodule

// File: tb/tb_rv_fetch_unit.sv
// Bench for rv_fetch_unit: directed scenarios plus random traffic against a queue-based model.
module tb_rv_fetch_unit;
    localparam int          XLEN  = 64;
    localparam int          DEPTH = 4;
    localparam logic [63:0] RPC   = 64'h1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic [2:0]  fifo_count;
`ifdef RV_FETCH_PERF_EN
    logic [31:0] fetch_stall_cycles;
`endif

    always #5 clk = ~clk;

    rv_fetch_unit #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .fifo_count     (fifo_count)
`ifdef RV_FETCH_PERF_EN
       ,.fetch_stall_cycles (fetch_stall_cycles)
`endif
    );

    int vecs = 0;
    int errs = 0;

    // Reference model: next fetch address, one optional outstanding pc, and a queue of buffered pcs.
    logic [63:0] m_pc = RPC;
    logic [63:0] m_ipc = '0;
    bit          m_inf = 1'b0;
    logic [63:0] m_q[$];
    int unsigned m_stall = 0;

    // Instruction memory: answers every accepted request exactly one cycle later.
    bit          pend = 1'b0;
    logic [63:0] pend_addr = '0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit rv, input logic [63:0] rpc,
                       input bit ordy, input bit mrdy, input bit stray);
        bit          exp_req;
        bit          acc;
        logic [63:0] acc_addr;
        reset          = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = ordy;
        imem_req_ready = mrdy;
        imem_rsp_valid = pend | stray;
        imem_rsp_data  = pend ? mem_word(pend_addr) : 32'hDEAD_BEEF;
        @(negedge clk);
        exp_req = !r && !rv && ((m_q.size() + int'(m_inf)) < DEPTH);
        chk("req_valid", {63'd0, imem_req_valid}, {63'd0, exp_req});
        if (!r) begin
            if (exp_req) chk("req_addr", imem_req_addr, m_pc);
            chk("fifo_count", {61'd0, fifo_count}, 64'(m_q.size()));
            chk("out_valid", {63'd0, out_valid}, {63'd0, m_q.size() != 0});
            if (m_q.size() != 0) begin
                chk("out_pc", out_pc, m_q[0]);
                chk("out_inst", {32'd0, out_inst}, {32'd0, mem_word(m_q[0])});
            end
`ifdef RV_FETCH_PERF_EN
            chk("stall_cycles", {32'd0, fetch_stall_cycles}, {32'd0, m_stall});
`endif
        end
        acc      = imem_req_valid && mrdy;
        acc_addr = imem_req_addr;
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_inf   = 1'b0;
            m_pc    = RPC;
            m_stall = 0;
        end else begin
            if (ordy && m_q.size() == 0 && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (rv) begin
                m_q.delete();
                m_inf = 1'b0;
                m_pc  = rpc & ~64'h3;
            end else begin
                if (ordy && m_q.size() != 0) void'(m_q.pop_front());
                if (m_inf) m_q.push_back(m_ipc);
                if (exp_req && mrdy) begin
                    m_ipc = m_pc;
                    m_pc  = m_pc + 64'd4;
                    m_inf = 1'b1;
                end else begin
                    m_inf = 1'b0;
                end
            end
        end
        pend      = acc;
        pend_addr = acc_addr;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

        // Reset with stray responses in the reset cycle and the one after
        cyc(1, 0, 0, 1, 1, 0);
        cyc(1, 0, 0, 1, 1, 1);
        cyc(0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, 1, 0);

        // Decode stalled: buffer fills to depth, then drains in order
        cyc(0, 1, 64'h3000, 0, 1, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 1, 0);

        // Redirect with three buffered entries and one in flight
        cyc(0, 1, 64'h1100, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 1, 64'h2002, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 1, 0);

        // Back-to-back redirects, last one wins
        cyc(0, 1, 64'h5000, 1, 1, 0);
        cyc(0, 1, 64'h6004, 1, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1, 0);

        // Memory ready toggling
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, (i % 2) == 0, 0);

        // Address wrap, then reset mid-stream with stray responses
        cyc(0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 1, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 1, 0);
        cyc(1, 0, 0, 1, 1, 1);
        cyc(0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 1, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [63:0] tgt;
            tgt = {$urandom(), $urandom()};
            cyc(0, $urandom_range(15) == 0, tgt, $urandom_range(2) != 0, $urandom_range(3) != 0, 0);
        end

        // Memory held off for 10 cycles after reset with decode ready
        cyc(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/rv_fetch_unit.md
Name: rv_fetch_unit

Overview:
Parametrised instruction-fetch front end for the next-generation RISC-V core; it replaces the bare PC register plus +4 adder path with a decoupled unit. Owns the PC, issues requests to a 1-cycle-latency instruction memory, and buffers fetched {pc, instruction} pairs in a flushable FIFO. Feeds decode through a valid/ready handshake. Accepts taken-branch/jump redirects from execute.

Parameters:
XLEN, 64, PC and address width in bits
FIFO_DEPTH, 4, fetch buffer entries; must be at least 2
RESET_PC, 0, PC value loaded on reset (word aligned)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_req_valid  out  1  fetch request
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  XLEN  fetch address (current PC)
imem_rsp_valid  in  1  response data valid; exactly 1 cycle after an accepted request
imem_rsp_data  in  32  fetched instruction
redirect_valid  in  1  execute redirects the PC
redirect_pc  in  XLEN  redirect target
out_valid  out  1  FIFO head valid
out_ready  in  1  decode accepts head
out_inst  out  32  head instruction
out_pc  out  XLEN  head PC
fifo_count  out  $clog2(FIFO_DEPTH+1)  occupied entries

Behaviour:
- Reset: fetch_pc=RESET_PC; count=0; inflight=0; out_valid=0; imem_req_valid=0. Any imem_rsp_valid in the reset cycle or the cycle after reset is dropped.
- Issue rule: imem_req_valid=1 iff !reset && !redirect_valid && (count + inflight) < FIFO_DEPTH. Pops in the same cycle do not grant credit. imem_req_addr = fetch_pc.
- Accept: on imem_req_valid && imem_req_ready, fetch_pc += 4 (mod 2^XLEN, wraps), inflight_pc=fetch_pc, inflight=1. Otherwise inflight=0 next cycle. At most one request is outstanding at a cycle boundary, so full-rate back-to-back streaming is possible.
- Response: if imem_rsp_valid && inflight && !flush_pending, push {inflight_pc, imem_rsp_data}. A response with inflight=0 is ignored, and the simulation assertion fires.
- Latency: request accepted in cycle N, data in cycle N+1, out_valid=1 in cycle N+2. No bypass around the FIFO.
- Pop: on out_valid && out_ready, advance the read pointer. Push and pop in the same cycle leaves count unchanged. Pointers wrap modulo FIFO_DEPTH. FIFO_DEPTH need not be a power of two.
- Redirect: redirect_valid has priority over all other events in that cycle.
  - Next cycle: fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}; count=0; pointers=0; out_valid=0.
  - Flush_pending drops the response for a request accepted before the redirect.
  - No request is issued during the redirect cycle.
  - A pop completing in the redirect cycle is legal; decode owns squashing it.
- Back-to-back redirects: the last one wins.
- out_inst/out_pc hold their value while out_valid && !out_ready.

Optional Feature:
RV_FETCH_PERF_EN
- Defined: adds output fetch_stall_cycles (32 bits, reset 0, saturating at 0xFFFF_FFFF). It increments every cycle where out_ready=1 && out_valid=0 && !reset.
- Undefined: the port and counter are absent, and area is unchanged.

Decomposition:
- Package rv_pkg:
  - XLEN default
  - INST_W=32
  - PC_STEP=4
  - NOP_INST=32'h0000_0013
  - typedef fetch_entry_t {pc, inst}
- Sub-module fetch_fifo: synchronous FIFO with push/pop/flush, count output and parametrised depth. The PC/issue/redirect logic stays in rv_fetch_unit.

Test Plan:
- Reset release, RESET_PC=0x1000, imem always ready, out_ready=1 -> requests at 0x1000, 0x1004, 0x1008...; first out_valid 2 cycles after the first accept; out_pc sequence matches; one instruction per cycle sustained.
- out_ready=0 from start, DEPTH=4 -> exactly 4 requests issued, fifo_count=4, imem_req_valid=0 thereafter; releasing out_ready drains 4 entries in order with no loss or duplication.
- Redirect to 0x2002 while one request is in flight and FIFO holds 3 -> next cycle fifo_count=0, out_valid=0; in-flight response discarded; next request addr=0x2000.
- imem_req_ready toggling 1,0,1,0 -> fetch_pc advances only on accepted cycles; out_pc strictly +4 per instruction with no gaps.
- fetch_pc=2^64-4 streaming -> next address wraps to 0x0; reset asserted mid-stream -> out_valid=0 and count=0 next cycle; stray response after reset is not pushed.
- RV_FETCH_PERF_EN defined, out_ready=1, imem_req_ready held 0 for 10 cycles after reset -> fetch_stall_cycles=10 plus the 2 initial latency cycles, i.e. 12.
